// File: rtl/fp_normalize_pack_pkg.sv
// Shared constants and types for the normalize/pack stage that follows the
// mantissa add/sub ALU.
//   - field widths and the exponent bias of IEEE754 single precision
//   - FSM state encoding (IDLE -> NORM -> DONE)
//   - selector telling the packer which kind of word to build
//   - packed result bundle (32-bit word + exception flags)
package fp_normalize_pack_pkg;

  localparam int MANT_W   = 24;   // incl. hidden bit
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int WORD_W   = 1 + EXP_W + FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PK_NORMAL = 2'd0,
    PK_ZERO   = 2'd1,
    PK_OVF    = 2'd2,
    PK_UNF    = 2'd3
  } pack_sel_e;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              zero;
    logic              ovf;
    logic              unf;
  } pack_res_t;

endpackage

// File: rtl/fp_normalize_pack_pack.sv
// fp_pack: combinational packer. Builds the IEEE754 single word from the
// normalized sign/exponent/fraction or one of the special encodings and
// raises the matching flag (flags are mutually exclusive by construction).
//   sign_i  result sign
//   exp_i   biased exponent (already in range 1..254 for PK_NORMAL)
//   frac_i  fraction bits below the hidden one
//   sel_i   which word to build
//   res_o   word + zero/overflow/underflow flags
module fp_pack
  import fp_normalize_pack_pkg::*;
(
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  pack_sel_e         sel_i,
  output pack_res_t         res_o
);

  always_comb begin
    res_o = '0;
    unique case (sel_i)
      PK_NORMAL: res_o.word = {sign_i, exp_i, frac_i};
      PK_ZERO: begin
        // exact cancellation always yields +0
        res_o.word = '0;
        res_o.zero = 1'b1;
      end
      PK_OVF: begin
        res_o.word = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        res_o.ovf  = 1'b1;
      end
      PK_UNF: begin
        res_o.word = {sign_i, {(WORD_W-1){1'b0}}};
        res_o.unf  = 1'b1;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: takes the ALU's 25-bit magnitude (bit 24 = carry),
// sign and common biased exponent, normalizes one bit per cycle and packs
// a single-precision word. Truncation, flush-to-zero, valid/ready on both
// sides, one item in flight.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (ready only in IDLE)
//   mant_in, sign_in, exp_in  ALU result
//   out_valid/out_ready output handshake (valid only in DONE)
//   result              {sign, exp, frac}
//   zero/overflow/underflow  exception flags, held with result
module fp_normalize_pack
  import fp_normalize_pack_pkg::*;
#(
  parameter int P_MANT_W  = MANT_W,
  parameter int P_EXP_W   = EXP_W,
  parameter int P_EXP_MAX = EXP_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [P_MANT_W:0]   mant_in,
  input  logic                sign_in,
  input  logic [P_EXP_W-1:0]  exp_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   result,
  output logic                zero,
  output logic                overflow,
  output logic                underflow
);

  localparam int EW = P_EXP_W + 1;  // work exponent has headroom for the carry bump

  state_e            state_q, state_d;
  logic [P_MANT_W:0] m_q, m_d;
  logic [EW-1:0]     e_q, e_d;
  logic              s_q, s_d;
  logic              ovf_ld_q, ovf_ld_d;   // exp_in was all-ones at load
  pack_res_t         res_q, res_d;

  pack_sel_e         sel;
  pack_res_t         pk;

  fp_pack u_pack (
    .sign_i (s_q),
    .exp_i  (e_q[P_EXP_W-1:0]),
    .frac_i (m_q[FRAC_W-1:0]),
    .sel_i  (sel),
    .res_o  (pk)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    s_d      = s_q;
    ovf_ld_d = ovf_ld_q;
    res_d    = res_q;
    sel      = PK_NORMAL;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d      = mant_in;
          s_d      = sign_in;
          e_d      = {1'b0, exp_in};
          ovf_ld_d = (exp_in == P_EXP_W'(P_EXP_MAX));
          state_d  = ST_NORM;
        end
      end

      ST_NORM: begin
        if (ovf_ld_q || (m_q[P_MANT_W] && e_q == EW'(P_EXP_MAX - 1))) begin
          sel     = PK_OVF;
          state_d = ST_DONE;
        end else if (m_q == '0) begin
          sel     = PK_ZERO;
          state_d = ST_DONE;
        end else if (m_q[P_MANT_W]) begin
          // carry out of the add: one right shift, LSB truncated
          m_d = m_q >> 1;
          e_d = e_q + EW'(1);
        end else if ((!m_q[P_MANT_W-1] && e_q <= EW'(1)) || e_q == '0) begin
          // exponent would leave the normal range; exponent 0 with a
          // normalized mantissa would encode a denormal, so flush it too
          sel     = PK_UNF;
          state_d = ST_DONE;
        end else if (!m_q[P_MANT_W-1]) begin
          m_d = m_q << 1;
          e_d = e_q - EW'(1);
        end else begin
          sel     = PK_NORMAL;
          state_d = ST_DONE;
        end
        if (state_d == ST_DONE) res_d = pk;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          res_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      e_q      <= '0;
      s_q      <= 1'b0;
      ovf_ld_q <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      s_q      <= s_d;
      ovf_ld_q <= ovf_ld_d;
      res_q    <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q.word;
  assign zero      = res_q.zero;
  assign overflow  = res_q.ovf;
  assign underflow = res_q.unf;

endmodule

// File: tb/tb_fp_normalize_pack.sv
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_in;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, overflow, underflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_normalize_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: value-level view of normalization. Leading-zero count decides
  // the shift amount; the exponent range decides whether the result fits.
  // f = {zero, overflow, underflow}; lat = cycles from accept cycle to out_valid.
  task automatic model(input logic [24:0] m, input logic [7:0] e, input logic s,
                       output logic [31:0] w, output logic [2:0] f, output int lat);
    int msb, lz, ee;
    logic [24:0] t;
    logic [7:0]  eo;
    ee  = int'(e);
    lat = 2;
    f   = 3'b000;
    w   = 32'h0;
    if (e == 8'd255) begin
      w = {s, 8'hFF, 23'h0}; f = 3'b010;
    end else if (m == 25'h0) begin
      f = 3'b100;
    end else if (m[24]) begin
      if (e == 8'd254) begin
        w = {s, 8'hFF, 23'h0}; f = 3'b010;
      end else begin
        lat = 3;
        eo  = 8'(ee + 1);
        w   = {s, eo, m[23:1]};
      end
    end else begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (m[i]) msb = i;
      lz = 23 - msb;
      if (ee == 0) begin
        w = {s, 31'h0}; f = 3'b001;
      end else if (ee - lz >= 1) begin
        lat = 2 + lz;
        t   = m << lz;
        eo  = 8'(ee - lz);
        w   = {s, eo, t[22:0]};
      end else begin
        lat = 2 + ee - 1;
        w   = {s, 31'h0}; f = 3'b001;
      end
    end
  endtask

  task automatic run_item(input logic [24:0] m, input logic [7:0] e, input logic s,
                          input int stall, input string tag);
    logic [31:0] ew;
    logic [2:0]  ef;
    int          el, n, tmo;
    model(m, e, s, ew, ef, el);
    tmo = 0;
    while (!in_ready && tmo < 50) begin
      @(negedge clk); tmo++;
    end
    if (!in_ready) begin
      check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; mant_in = m; exp_in = e; sign_in = s;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(el));
    check({tag, "_result"}, result, ew);
    check({tag, "_flags"}, {29'h0, zero, overflow, underflow}, {29'h0, ef});
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_stall_result"}, result, ew);
      check({tag, "_stall_flags"}, {29'h0, zero, overflow, underflow}, {29'h0, ef});
      check({tag, "_stall_hs"}, {30'h0, out_valid, in_ready}, 32'h2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {26'h0, out_valid, in_ready, zero, overflow, underflow, 1'b0},
          32'h10);
  endtask

  initial begin
    logic [24:0] rm;
    logic [7:0]  re;
    int          w;
    rst = 1'b1; in_valid = 1'b0; mant_in = '0; sign_in = 1'b0; exp_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hs", {30'h0, out_valid, in_ready}, 32'h1);
    check("reset_result", result, 32'h0);
    check("reset_flags", {29'h0, zero, overflow, underflow}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_item(25'h0800000, 8'd127, 1'b0, 0, "one");
    run_item(25'h1000000, 8'd127, 1'b0, 0, "carry2");
    run_item(25'h1FFFFFF, 8'd127, 1'b0, 0, "carry_trunc");
    run_item(25'h0000073, 8'd150, 1'b0, 0, "d115");
    run_item(25'h0000000, 8'd127, 1'b1, 0, "cancel");
    run_item(25'h1000000, 8'd254, 1'b1, 0, "ovf_carry");
    run_item(25'h0000123, 8'd255, 1'b0, 0, "ovf_load");
    run_item(25'h0000001, 8'd5,   1'b0, 0, "unf_shift");
    run_item(25'h0800000, 8'd0,   1'b0, 0, "unf_exp0");
    run_item(25'h0000001, 8'd200, 1'b1, 0, "worst");
    run_item(25'h1800000, 8'd0,   1'b0, 0, "carry_exp0");
    run_item(25'h0400000, 8'd1,   1'b1, 0, "unf_e1");
    run_item(25'h0800000, 8'd127, 1'b1, 5, "stall5");

    // abort mid-normalization
    in_valid = 1'b1; mant_in = 25'h1; exp_in = 8'd150; sign_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_hs", {30'h0, out_valid, in_ready}, 32'h1);
    check("rst_mid_out", {result[31:3], zero | result[2], overflow | result[1],
          underflow | result[0]}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    run_item(25'h0C00000, 8'd100, 1'b0, 0, "post_rst");

    for (int i = 0; i < 300; i++) begin
      w  = int'($urandom_range(0, 25));
      rm = 25'($urandom) & ((25'h1 << w) - 25'h1);
      if (w == 25 && ($urandom_range(0, 1) == 0)) rm[24] = 1'b1;
      case ($urandom_range(0, 7))
        0: re = 8'd0;
        1: re = 8'd1;
        2: re = 8'd254;
        3: re = 8'd255;
        4: re = 8'($urandom_range(2, 24));
        default: re = 8'($urandom);
      endcase
      run_item(rm, re, 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
